// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Presents bytes to the core as uart_in / uart_empty / uart_rdreq.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       uart_rdreq,
  output logic [7:0] uart_in,
  output logic       uart_empty,
  output logic       uart_full,
  output logic       overrun,
  output logic       frame_err,
  input  logic       err_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int CNTW  = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0]   LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULLC = CNTW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic sync_q;
  logic rxs_q;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bitidx_q, bitidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        push;
  logic        ferr_set;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  do_push;
  logic                  do_pop;
  logic                  ovr_set;
  logic                  overrun_q, overrun_d;
  logic                  frame_err_q, frame_err_d;

  // Two-flop synchroniser; idles high so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      sync_q <= rxd;
      rxs_q  <= sync_q;
    end
  end

  // Receiver state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
    end
  end

  // Receiver next state: mid-bit sampling, glitch reject, break hold-off
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d    = '0;
          bitidx_d = '0;
          state_d  = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          shreg_d  = {rxs_q, shreg_q[7:1]};
          cnt_d    = '0;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rxs_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign uart_empty = (count_q == '0);
  assign uart_full  = (count_q == FULLC);
  assign uart_in    = uart_empty ? 8'h00 : mem[rd_ptr_q];
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

  // FIFO control: a pop on a full FIFO frees the slot for a same-cycle push
  always_comb begin
    do_pop      = uart_rdreq && !uart_empty;
    do_push     = push && (!uart_full || do_pop);
    ovr_set     = push && uart_full && !do_pop;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    overrun_d   = ovr_set  ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    frame_err_d = ferr_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
  end

  // FIFO pointers, occupancy and sticky error flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO storage; contents survive reset, only the pointers are cleared
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= shreg_q;
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive side of the CPU's UART I/O path. It deserialises 8N1 frames from the board's RX pin and buffers the bytes in a first-word-fall-through FIFO. It presents them to the core's data memory as the `uart_in` / `uart_empty` / `uart_rdreq` triple. It sits directly upstream of the core: the core pops one byte per `uart_rdreq` pulse when it executes an MMIO load from the UART address.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `rxd`  in  1  asynchronous serial input; idles at 1.
- `uart_rdreq`  in  1  pop request from the core; one byte popped per cycle high.
- `uart_in`  out  8  head-of-FIFO byte; 8'h00 while `uart_empty`=1.
- `uart_empty`  out  1  FIFO holds no bytes.
- `uart_full`  out  1  FIFO holds 2^DEPTH_LOG2 bytes.
- `overrun`  out  1  sticky: a received byte was dropped because the FIFO was full.
- `frame_err`  out  1  sticky: a stop bit was sampled as 0.
- `err_clr`  in  1  clears `overrun` and `frame_err`.

## Operation
- **Synchroniser.** `rxd` passes through a 2-flop synchroniser, reset to 1. All FSM decisions use the synchronised value `rxs`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxs`=0, go to START and set `cnt`=0.
  - START: `cnt` increments. When `cnt`==CLKS_PER_BIT/2−1 (integer division), sample `rxs`. If 0, go to DATA with `cnt`=0 and `bitidx`=0. If 1, treat it as a glitch and return to IDLE.
  - DATA: when `cnt`==CLKS_PER_BIT−1, shift `rxs` into `shreg` LSB-first, set `cnt`=0 and increment `bitidx`. After the 8th sample, go to STOP.
  - STOP: when `cnt`==CLKS_PER_BIT−1, sample `rxs`. If 1, push `shreg` and go to IDLE. If 0, set `frame_err`, discard the byte and go to BREAK.
  - BREAK: wait until `rxs`=1, then go to IDLE. This prevents a held-low line from retriggering.
- **FIFO.**
  - Storage: a 2^DEPTH_LOG2 × 8 array with DEPTH_LOG2-bit read and write pointers that wrap modulo depth.
  - `count` is DEPTH_LOG2+1 bits wide.
  - `uart_empty` = (`count`==0). `uart_full` = (`count`==depth).
  - `uart_in` = mem[rd_ptr] when not empty, else 8'h00.
- **Push and pop rules:**
  - Push while not full: write the byte, increment wr_ptr.
  - Push while full and no pop in the same cycle: drop the byte, set `overrun`.
  - Push and pop in the same cycle while full: both take effect, `count` is unchanged, no overrun.
  - Pop while empty: ignored. Pointers and `count` are unchanged, with no underflow.
  - Push and pop in the same cycle while empty: only the push takes effect.
- **Sticky flags.** If `err_clr` and a new error event occur in the same cycle, the flag is set (set wins).
- **Reset behaviour.**
  - Reset returns the FSM to IDLE and clears the pointers, `count`, `cnt`, `bitidx` and both sticky flags. FIFO contents are not cleared.
  - Reset during a frame abandons that frame. The remaining bits are ignored until `rxs` is seen at 0 from IDLE. Mid-frame data bits of value 0 may therefore start a spurious frame; this is acceptable.

## Timing
- **Reset values:** `uart_in`=8'h00, `uart_empty`=1, `uart_full`=0, `overrun`=0, `frame_err`=0.
- **Start detect:** the `rxd` falling edge reaches `rxs` after 2 clocks.
- **Sample points:**
  - Start bit: CLKS_PER_BIT/2 clocks after `rxs` falls.
  - Each data bit: CLKS_PER_BIT clocks after the previous sample.
  - Stop bit: CLKS_PER_BIT clocks after the last data bit.
- **Push latency:** the push occurs on the clock edge at which the stop bit is sampled. `uart_empty` falls and `uart_in` is valid in the following cycle.
- **End to end:** a byte appears about 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 clocks after the `rxd` falling edge.
- **Pop:** `uart_rdreq` high at edge N pops the head. The next byte (or 8'h00 with `uart_empty`=1) is visible after edge N. The core samples `uart_in` in the same cycle it asserts `uart_rdreq`.
- **Rate tolerance:** sustained back-to-back frames with a one-bit stop are accepted, because IDLE is re-entered half a bit before the next start edge.

## Test plan
All scenarios use CLKS_PER_BIT=8 and DEPTH_LOG2=2.
- **Single byte.** Reset, then drive frame 8'hA5 (bits 1,0,1,0,0,1,0,1 LSB-first, stop 1) → `uart_empty` falls about 2+4+72+1 clocks after the start edge, `uart_in`=8'hA5. One `uart_rdreq` pulse → `uart_empty`=1, `uart_in`=8'h00.
- **Burst and overrun.** Send 5 back-to-back frames 8'h01..8'h05 with no pops → `uart_full`=1 after 8'h04, `overrun`=1 after the 5th. Pops return 01, 02, 03, 04, then `uart_empty`=1. Pointer wrap is verified by sending 8'h06..8'h08 and popping them in order.
- **Simultaneous push/pop on full.** Fill 4 entries, then hold `uart_rdreq` high on the push edge of a 5th byte 8'h55 → `count` stays 4, `overrun`=0, 8'h55 is the last byte popped.
- **Glitch and framing.**
  - A 2-clock low pulse on `rxd` → no push, FSM back in IDLE.
  - A frame with stop=0 → `frame_err`=1 and nothing pushed; holding `rxd`=0 for 30 clocks causes no new frame.
  - `err_clr` → `frame_err`=0.
- **Reset mid-frame.** Assert `reset` during bit 3 of 8'hFF → empty FIFO, flags 0. The next full frame 8'h3C is received correctly.
- **Pop on empty.** Pulse `uart_rdreq` 3 times with the FIFO empty, then receive 8'h7E → the FIFO holds exactly one byte, 8'h7E.
